// File: rtl/register_file_pkg.sv
// Shared processor constants for the register file: default geometry, zero-register index
// and the saturating write-counter helper.
package register_file_pkg;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned NUM_REGS   = 2 ** ADDR_WIDTH;
    localparam int unsigned ZERO_REG   = 0;
    localparam int unsigned CNT_WIDTH  = 16;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
    endfunction

endpackage

// File: rtl/regfile_word.sv
// One register-file word: a loadable register with synchronous reset.
module regfile_word #(
    parameter int unsigned WIDTH = register_file_pkg::DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/register_file.sv
// Two-read / one-write register file with hardwired zero register, optional write-to-read
// forwarding, a one-cycle write acknowledge and a saturating committed-write counter.
module register_file #(
    parameter int unsigned DATA_WIDTH = register_file_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = register_file_pkg::ADDR_WIDTH,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] RA1,
    input  logic [ADDR_WIDTH-1:0] RA2,
    input  logic                  WE,
    input  logic [ADDR_WIDTH-1:0] WA,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2,
    output logic                  WR_ACK,
    output logic [15:0]           WR_COUNT
);

    import register_file_pkg::CNT_WIDTH;
    import register_file_pkg::ZERO_REG;
    import register_file_pkg::sat_inc;

    localparam int unsigned           NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX  = ADDR_WIDTH'(ZERO_REG);

    logic                  wr_fwd_c;
    logic                  wr_commit_c;
    logic [DATA_WIDTH-1:0] word_q [NUM_WORDS];

    logic                  wr_ack_q;
    logic                  wr_ack_d;
    logic [CNT_WIDTH-1:0]  wr_count_q;
    logic [CNT_WIDTH-1:0]  wr_count_d;

    // Forwarding ignores RST so that reads between edges still see the incoming data
    always_comb begin
        wr_fwd_c    = WE && (WA != ZERO_IDX);
        wr_commit_c = wr_fwd_c && !RST;
    end

    // Storage: zero register is a constant, every other word gets its own decoded load
    for (genvar i = 0; i < NUM_WORDS; i++) begin : g_word
        if (i == ZERO_REG) begin : g_zero
            assign word_q[i] = '0;
        end else begin : g_reg
            regfile_word #(
                .WIDTH (DATA_WIDTH)
            ) u_word (
                .clk  (CLK),
                .rst  (RST),
                .load (wr_commit_c && (WA == ADDR_WIDTH'(i))),
                .d    (WD),
                .q    (word_q[i])
            );
        end
    end

    // Combinational read muxes with optional same-cycle forwarding
    always_comb begin
        RD1 = word_q[RA1];
        RD2 = word_q[RA2];
        if (BYPASS && wr_fwd_c && (RA1 == WA)) begin
            RD1 = WD;
        end
        if (BYPASS && wr_fwd_c && (RA2 == WA)) begin
            RD2 = WD;
        end
    end

    always_comb begin
        wr_ack_d   = wr_commit_c;
        wr_count_d = wr_count_q;
        if (wr_commit_c) begin
            wr_count_d = sat_inc(wr_count_q);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ack_q   <= 1'b0;
            wr_count_q <= '0;
        end else begin
            wr_ack_q   <= wr_ack_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign WR_ACK   = wr_ack_q;
    assign WR_COUNT = wr_count_q;

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: one forwarding and one non-forwarding instance share
// the stimulus; each driven cycle queues its expected outputs for a negedge monitor.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra1, ra2, wa;
    logic        we;
    logic [31:0] wd;

    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        ack_b, ack_n;
    logic [15:0] cnt_b, cnt_n;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] n1;
        logic [31:0] n2;
        logic        ack;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) dut_b (
        .CLK(clk), .RST(rst), .RA1(ra1), .RA2(ra2), .WE(we), .WA(wa), .WD(wd),
        .RD1(rd1_b), .RD2(rd2_b), .WR_ACK(ack_b), .WR_COUNT(cnt_b)
    );

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) dut_n (
        .CLK(clk), .RST(rst), .RA1(ra1), .RA2(ra2), .WE(we), .WA(wa), .WD(wd),
        .RD1(rd1_n), .RD2(rd2_n), .WR_ACK(ack_n), .WR_COUNT(cnt_n)
    );

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
        end
    endtask

    // Monitor: pop one expectation per driven cycle, mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk(e.name, "rd1_byp",   rd1_b, e.e1);
            chk(e.name, "rd2_byp",   rd2_b, e.e2);
            chk(e.name, "rd1_nobyp", rd1_n, e.n1);
            chk(e.name, "rd2_nobyp", rd2_n, e.n2);
            chk(e.name, "ack_byp",   32'(ack_b), 32'(e.ack));
            chk(e.name, "ack_nobyp", 32'(ack_n), 32'(e.ack));
            chk(e.name, "cnt_byp",   32'(cnt_b), 32'(e.cnt));
            chk(e.name, "cnt_nobyp", 32'(cnt_n), 32'(e.cnt));
        end
    end

    task automatic drive(input logic r, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input logic [4:0] p1, input logic [4:0] p2);
        @(posedge clk);
        #1;
        rst = r; we = w; wa = a; wd = d; ra1 = p1; ra2 = p2;
    endtask

    // One driven cycle plus its expectation (forwarding and stored-only read values)
    task automatic step(input string nm, input logic r, input logic w, input logic [4:0] a,
                        input logic [31:0] d, input logic [4:0] p1, input logic [4:0] p2,
                        input logic [31:0] e1, input logic [31:0] e2,
                        input logic [31:0] n1, input logic [31:0] n2,
                        input logic ack, input logic [15:0] cnt);
        exp_t e;
        drive(r, w, a, d, p1, p2);
        e.name = nm; e.e1 = e1; e.e2 = e2; e.n1 = n1; e.n2 = n2; e.ack = ack; e.cnt = cnt;
        sb_q.push_back(e);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        repeat (2) @(posedge clk);

        // Reset clears everything
        for (int i = 0; i < 16; i++) begin
            step($sformatf("reset_rd%0d", i), 0, 0, 0, 0, 5'(i), 5'(i + 16),
                 0, 0, 0, 0, 0, 16'd0);
        end

        // Single write to reg 5
        step("wr5",      0, 1, 5, 32'hDEADBEEF, 5, 6, 32'hDEADBEEF, 0, 0, 0, 0, 16'd0);
        step("wr5_rd",   0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF,
             32'hDEADBEEF, 32'hDEADBEEF, 1, 16'd1);
        step("wr5_idle", 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 0, 16'd1);

        // Write to reg 0 is discarded
        step("wr0",      0, 1, 0, 32'hFFFFFFFF, 0, 5, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 16'd1);
        step("wr0_rd",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd1);
        step("wr0_rd2",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'd1);

        // Forwarding on back-to-back writes to reg 7
        step("wr7a",     0, 1, 7, 32'h1, 7, 5, 32'h1, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 16'd1);
        step("wr7b",     0, 1, 7, 32'h2, 7, 7, 32'h2, 32'h2, 32'h1, 32'h1, 1, 16'd2);
        step("wr7_rd",   0, 0, 0, 0, 7, 7, 32'h2, 32'h2, 32'h2, 32'h2, 1, 16'd3);
        step("wr7_idle", 0, 0, 0, 0, 7, 5, 32'h2, 32'hDEADBEEF, 32'h2, 32'hDEADBEEF, 0, 16'd3);

        // Reset beats a simultaneous write; reads stay pre-reset until the edge
        step("rst_wr3",  1, 1, 3, 32'hA5A5A5A5, 3, 5, 32'hA5A5A5A5, 32'hDEADBEEF,
             0, 32'hDEADBEEF, 0, 16'd3);
        step("rst_rd",   0, 0, 0, 0, 3, 5, 0, 0, 0, 0, 0, 16'd0);
        step("rst_rd2",  0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 16'd0);

        // First write after reset
        step("wr9",      0, 1, 9, 32'h12345678, 9, 9, 32'h12345678, 32'h12345678, 0, 0, 0, 16'd0);
        step("wr9_rd",   0, 0, 0, 0, 9, 3, 32'h12345678, 0, 32'h12345678, 0, 1, 16'd1);

        // Unknown write address with WE low must not disturb storage
        step("wa_x",     0, 0, 5'bx, 32'hFFFFFFFF, 9, 5, 32'h12345678, 0, 32'h12345678, 0, 0, 16'd1);
        step("wa_x_rd",  0, 0, 0, 0, 9, 5, 32'h12345678, 0, 32'h12345678, 0, 0, 16'd1);

        // Top register index
        step("wr31",     0, 1, 31, 32'hCAFEF00D, 31, 0, 32'hCAFEF00D, 0, 0, 0, 0, 16'd1);
        step("wr31_rd",  0, 0, 0, 0, 31, 9, 32'hCAFEF00D, 32'h12345678,
             32'hCAFEF00D, 32'h12345678, 1, 16'd2);

        // Counter saturation: 65536 writes to reg 1 with WD = loop index
        for (int i = 0; i < 65536; i++) begin
            if (i >= 65532) begin
                step($sformatf("sat%0d", i), 0, 1, 1, 32'(i), 1, 1, 32'(i), 32'(i),
                     32'(i - 1), 32'(i - 1), 1, (i + 2 > 65535) ? 16'hFFFF : 16'(i + 2));
            end else begin
                drive(0, 1, 1, 32'(i), 1, 1);
            end
        end
        step("sat_rd",   0, 0, 0, 0, 1, 31, 32'h0000FFFF, 32'hCAFEF00D,
             32'h0000FFFF, 32'hCAFEF00D, 1, 16'hFFFF);
        step("sat_wr2",  0, 1, 2, 32'h55AA55AA, 2, 1, 32'h55AA55AA, 32'h0000FFFF,
             0, 32'h0000FFFF, 0, 16'hFFFF);
        step("sat_hold", 0, 0, 0, 0, 2, 1, 32'h55AA55AA, 32'h0000FFFF,
             32'h55AA55AA, 32'h0000FFFF, 1, 16'hFFFF);

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 8 && sb_q.size() != 0; k++) @(posedge clk);
        tests++;
        if (sb_q.size() != 0) begin
            failed++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 32, meaning the bit width of each register word.
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 5, meaning the register index width (32 registers).
REQ-003 The block SHALL expose parameter BYPASS, default 1, meaning 1 = same-cycle write-to-read forwarding and 0 = read returns the stored value only.
REQ-004 CLK  input  1  single clock; all state updates on its rising edge.
REQ-005 RST  input  1  synchronous active-high reset, sampled on the rising edge of CLK.
REQ-006 RA1  input  ADDR_WIDTH  read port 1 index (rs).
REQ-007 RA2  input  ADDR_WIDTH  read port 2 index (rt).
REQ-008 WE  input  1  write enable.
REQ-009 WA  input  ADDR_WIDTH  write index (rd/rt from the write-back mux).
REQ-010 WD  input  DATA_WIDTH  write data.
REQ-011 RD1  output  DATA_WIDTH  read data for RA1.
REQ-012 RD2  output  DATA_WIDTH  read data for RA2.
REQ-013 WR_ACK  output  1  registered pulse, high for exactly one cycle after a write commits to a nonzero register.
REQ-014 WR_COUNT  output  16  registered count of committed writes, saturating at 16'hFFFF.

Function
REQ-015 Storage SHALL be 2^ADDR_WIDTH words of DATA_WIDTH bits, and register 0 SHALL read as 0 at all times.
REQ-016 Reads SHALL be combinational: RD1/RD2 SHALL reflect the addressed word in the same cycle with zero clock latency.
REQ-017 A write SHALL commit on the rising edge of CLK when WE=1, RST=0 and WA!=0, and SHALL be visible in storage from the following cycle.
REQ-018 A write with WA=0 SHALL be discarded, SHALL NOT assert WR_ACK and SHALL NOT increment WR_COUNT.
REQ-019 With BYPASS=1, when WE=1, WA!=0 and RAx==WA, RDx SHALL equal WD in the same cycle.
REQ-020 With BYPASS=0, under the same condition, RDx SHALL equal the old stored value until the edge.
REQ-021 Both read ports SHALL be able to address the same register, or the write register, simultaneously without conflict.
REQ-022 WR_ACK SHALL be set on any edge that commits a write and cleared on every other edge.
REQ-023 WR_COUNT SHALL increment by 1 per committed write and SHALL hold at 16'hFFFF with no wrap-around.
REQ-024 X or Z on WA while WE=0 SHALL NOT alter storage.

Reset
REQ-025 On an edge with RST=1, all words SHALL be cleared to 0, WR_ACK to 0 and WR_COUNT to 0.
REQ-026 RST SHALL take priority over a simultaneous write: that write is lost and WR_ACK stays 0.
REQ-027 RST SHALL have no asynchronous effect; between edges, RD1/RD2 SHALL still show the pre-reset contents, except for bypassed values.
REQ-028 Reset asserted mid-sequence SHALL leave no partial state, and the first write after reset deassertion SHALL behave as in REQ-017.

Structure
REQ-029 DATA_WIDTH, ADDR_WIDTH, register count and the ZERO_REG index SHALL live in the shared processor constants package/include.
REQ-030 Each word SHALL be one instance of sub-module regfile_word: a DATA_WIDTH enabled register with synchronous reset and load enable driven by the write-address decode.
REQ-031 The write decoder, read muxes, bypass compare and counter SHALL reside in register_file.

Verification
REQ-032 Scenario 1: RST=1 for one edge, then read all 32 indices -> all values 0, WR_COUNT=0.
REQ-033 Scenario 2: write WA=5, WD=32'hDEADBEEF, then read RA1=5 next cycle -> RD1=32'hDEADBEEF, WR_ACK high one cycle, WR_COUNT=1.
REQ-034 Scenario 3: write WA=0, WD=32'hFFFFFFFF -> RD1 for RA1=0 stays 0, WR_ACK stays 0, WR_COUNT unchanged.
REQ-035 Scenario 4: reg 7=32'h1, then in the same cycle WE=1, WA=7, WD=32'h2, RA1=RA2=7 -> RD1=RD2=32'h2 for BYPASS=1, or 32'h1 then 32'h2 next cycle for BYPASS=0.
REQ-036 Scenario 5: RST=1 and WE=1, WA=3, WD=32'hA5A5A5A5 on the same edge -> reg 3 reads 0, WR_ACK=0.
REQ-037 Scenario 6: force 65536 writes to WA=1 -> WR_COUNT saturates at 16'hFFFF, and reg 1 holds the last WD.
